vga_fb_wb_slave: RTL and testbench
==================================

Name: vga_fb_wb_slave

Overview:
- Wishbone B3 slave modelling the framebuffer memory that the VGA core's master port reads pixel data from.
- It is the responder end of the wbm interface that fills the core's fb_data_fifo. It serves classic single reads and writes plus CTI-tagged incrementing and wrapping bursts, with configurable wait states.
- It is used in the VGA bench and FPGA demo in place of external SDRAM; the preload path uses the same write port.

Parameters:
- AW, 12, word-address width; memory depth is 2**AW 32-bit words.
- BASE_ADR, 32'h0000_0000, window base; compared on wbs_adr_i[31:AW+2].
- WAIT_STATES, 1, idle cycles before the first ack of any access (0..15).
- BURST_WAIT, 0, idle cycles between burst beats (0..3).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_cyc_i  in  1  cycle valid.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  write enable.
- wbs_adr_i  in  32  byte address.
- wbs_sel_i  in  4  byte-lane select.
- wbs_dat_i  in  32  write data.
- wbs_cti_i  in  3  cycle type: 000 classic, 010 incrementing, 111 end-of-burst.
- wbs_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- wbs_dat_o  out  32  read data.
- wbs_ack_o  out  1  acknowledge.
- wbs_err_o  out  1  error.
- rd_cnt_o  out  16  acked read beats, saturating at 16'hFFFF.
- burst_active_o  out  1  high while in BURST state.

Behaviour:
- Reset (synchronous, active-high): state IDLE; wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0, rd_cnt_o=0, burst_active_o=0; wait counter 0. Memory contents are not reset.
- req = wbs_cyc_i & wbs_stb_i.
- wbs_ack_o = ack_r & req and wbs_err_o = err_r & req. Both are gated combinationally, so neither is ever high while stb is low. On the cycle after the last acked beat, when the master drops stb, ack is low.
- Decode error condition: wbs_adr_i[31:AW+2] != BASE_ADR[31:AW+2], or wbs_adr_i[1:0] != 0.
- State IDLE:
  - req with decode error -> ERR. err_r=1 for exactly one cycle, no memory access, then IDLE.
  - req, decoded, WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
  - req, decoded, WAIT_STATES=0 -> ACK directly.
  - The address index adr[AW+1:2] is latched on entry.
- State WAIT: counts down; at 0 -> ACK. Req dropping in WAIT -> IDLE, no ack, no write.
- State ACK: ack_r=1 for one cycle.
  - Read: wbs_dat_o holds mem[idx]. RAM read is issued in the WAIT/IDLE cycle, so data is valid with ack.
  - Write: mem[idx] is updated per wbs_sel_i lane on the acked edge.
  - Next state:
    - cti=010 and req -> BURST.
    - Otherwise -> IDLE; a new request is only accepted in IDLE.
- State BURST: burst_active_o=1.
  - Index advance per beat:
    - bte=00: idx+1 modulo 2**AW (silent wrap at window end).
    - bte=01/10/11: low 2/3/4 index bits increment and wrap; upper bits are held.
  - Next data is prefetched, so with BURST_WAIT=0 ack_r stays high every cycle (one beat per clock).
  - With BURST_WAIT=N, ack_r pulses 1 cycle on, N cycles off.
  - A beat acked with cti=111 ends the burst -> IDLE, ack_r=0 next cycle.
  - Req low in BURST (early termination) -> IDLE immediately. The pending prefetch is discarded and there is no write side effect.
- wbs_dat_o holds its last value between reads and is not cleared on write.
- rd_cnt_o increments on each cycle where wbs_ack_o=1 and wbs_we_i=0.
- Synchronous reset mid-burst returns to IDLE next edge, ack low. RAM writes already committed persist.

Decomposition:
- Package vga_fb_pkg:
  - CTI constants: CTI_CLASSIC, CTI_INCR, CTI_EOB.
  - BTE constants: BTE_LINEAR, BTE_WRAP4, BTE_WRAP8, BTE_WRAP16.
  - State enum: IDLE, WAIT, ACK, BURST, ERR.
  - Function next_idx(idx, bte).
- Sub-module vga_fb_ram: single-port synchronous RAM, 2**AW x 32, byte-enable write, 1-cycle read latency.

Test Plan:
- Classic write 32'hA5A5_1234 to 0x10 with sel=4'b0011, then read 0x10 (memory pre-filled 32'hFFFF_FFFF; WAIT_STATES=1) -> read data 32'hFFFF_1234; ack exactly 1 cycle, 2 cycles after stb rises; ack low on the cycle stb falls.
- Linear burst, 8 beats from word 0 (mem[i]=i, BURST_WAIT=0) -> data 0..7 on 8 consecutive acked cycles; last beat cti=111; ack=0 next cycle; rd_cnt_o=8.
- Wrap4 burst starting at word 6, 4 beats -> data order 6, 7, 4, 5.
- Linear burst starting at word 2**AW-1, 2 beats -> data mem[4095], then mem[0].
- Access to address 0x0000_4000 (outside window, AW=12) -> wbs_err_o for 1 cycle; no ack; memory unchanged.
- Master drops stb after 3 beats of an incrementing burst with cti still 010 -> ack low on that same cycle; IDLE next; a following classic read acks normally; rd_cnt_o=3.
- Assert wb_rst_i during the WAIT state -> no ack appears.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared constants, FSM state type and burst index arithmetic for the
// framebuffer Wishbone slave.
package vga_fb_pkg;

    // Wishbone cycle type identifiers (wbs_cti_i)
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Wishbone burst type identifiers (wbs_bte_i)
    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACK,
        BURST,
        ERR
    } fb_state_e;

    // Next word index of a burst. Linear bursts carry through all bits, so the
    // caller truncating to its index width gives a silent wrap at the window
    // end. Wrapping bursts only move the low 2/3/4 bits and hold the rest.
    // Indices are carried as 16 bits, which covers every supported AW.
    function automatic logic [15:0] next_idx(input logic [15:0] idx,
                                             input logic [1:0]  bte);
        logic [15:0] n;
        n = idx;
        case (bte)
            BTE_LINEAR: n = idx + 16'd1;
            BTE_WRAP4:  n[1:0] = idx[1:0] + 2'd1;
            BTE_WRAP8:  n[2:0] = idx[2:0] + 3'd1;
            default:    n[3:0] = idx[3:0] + 4'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vga_fb_ram.sv
// Single-port synchronous RAM, 2**AW x 32, byte-lane write enables and a
// registered read port. The read register only loads when rd_en_i is high,
// so it holds the last word read across writes and idle cycles.
module vga_fb_ram #(
    parameter int AW = 12
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          rd_en_i,
    input  logic          we_i,
    input  logic [3:0]    sel_i,
    input  logic [AW-1:0] adr_i,
    input  logic [31:0]   dat_i,
    output logic [31:0]   dat_o
);

    logic [31:0] mem_q [2**AW];
    logic [31:0] dat_q;

    // Byte-lane write; the array itself has no reset so contents survive it
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_i[b]) begin
                    mem_q[adr_i][8*b +: 8] <= dat_i[8*b +: 8];
                end
            end
        end
    end

    // Read data register, cleared by reset and loaded only on a read request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dat_q <= '0;
        end else if (rd_en_i) begin
            dat_q <= mem_q[adr_i];
        end
    end

    assign dat_o = dat_q;

endmodule

// File: rtl/vga_fb_wb_slave.sv
// Wishbone B3 slave standing in for the VGA framebuffer memory. Serves
// classic cycles and CTI-tagged incrementing/wrapping bursts with
// configurable initial wait states and inter-beat gaps.
//
// Handshake: a beat is requested while cyc & stb are high and completes on
// the rising edge where ack (or err) is high. ack/err are gated with cyc & stb
// combinationally, so a master that drops stb never sees a stale response and
// a beat without stb never writes memory or counts as a read.
module vga_fb_wb_slave
    import vga_fb_pkg::*;
#(
    parameter int          AW          = 12,
    parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
    parameter int          WAIT_STATES = 1,
    parameter int          BURST_WAIT  = 0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [2:0]  wbs_cti_i,
    input  logic [1:0]  wbs_bte_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic [15:0] rd_cnt_o,
    output logic        burst_active_o
);

    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);
    localparam logic [3:0] BW_LOAD = 4'(BURST_WAIT);

    fb_state_e     state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [15:0]   rd_cnt_q;

    logic          req, dec_err, ack_r, err_r, beat;
    logic [AW-1:0] adr_idx, nidx, ram_adr;
    logic          ram_rd, ram_we;

    assign req     = wbs_cyc_i & wbs_stb_i;
    assign dec_err = (wbs_adr_i[31:AW+2] != BASE_ADR[31:AW+2]) | (|wbs_adr_i[1:0]);
    assign adr_idx = wbs_adr_i[AW+1:2];
    assign nidx    = AW'(next_idx(16'(idx_q), wbs_bte_i));

    // Registered response flags: ACK always responds, BURST responds once its
    // inter-beat gap counter has run out.
    assign ack_r = (state_q == ACK) | ((state_q == BURST) & (cnt_q == 4'd0));
    assign err_r = (state_q == ERR);
    assign beat  = ack_r & req;

    assign wbs_ack_o      = beat;
    assign wbs_err_o      = err_r & req;
    assign rd_cnt_o       = rd_cnt_q;
    assign burst_active_o = (state_q == BURST);

    // Next-state logic; RAM reads are issued on the edge that enters an
    // acknowledging cycle so the data is already registered when ack rises.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ram_rd  = 1'b0;
        ram_adr = idx_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d = adr_idx;
                    if (dec_err) begin
                        state_d = ERR;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ACK;
                        ram_rd  = ~wbs_we_i;
                        ram_adr = adr_idx;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = ACK;
                    ram_rd  = ~wbs_we_i;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK, BURST: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (ack_r) begin
                    if (wbs_cti_i == CTI_INCR) begin
                        state_d = BURST;
                        cnt_d   = BW_LOAD;
                        idx_d   = nidx;
                        if (BURST_WAIT == 0) begin
                            ram_rd  = ~wbs_we_i;
                            ram_adr = nidx;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        ram_rd = ~wbs_we_i;
                    end
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A write beat always targets the beat's own index
        if (beat && wbs_we_i) begin
            ram_adr = idx_q;
        end
    end

    assign ram_we = beat & wbs_we_i & ~wb_rst_i;

    // State, counters and the saturating read-beat counter
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            if (beat && !wbs_we_i && rd_cnt_q != 16'hFFFF) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    vga_fb_ram #(
        .AW(AW)
    ) u_ram (
        .clk_i  (wb_clk_i),
        .rst_i  (wb_rst_i),
        .rd_en_i(ram_rd),
        .we_i   (ram_we),
        .sel_i  (wbs_sel_i),
        .adr_i  (ram_adr),
        .dat_i  (wbs_dat_i),
        .dat_o  (wbs_dat_o)
    );

endmodule

// File: tb/tb_vga_fb_wb_slave.sv
// Self-checking bench for vga_fb_wb_slave: a word-array memory model and a
// read-data expectation queue drained by an independent ack monitor.
module tb_vga_fb_wb_slave;
  import vga_fb_pkg::*;

  localparam int AW = 12;
  localparam int DEPTH = 4096;
  localparam int WS = 1;
  localparam int BW = 0;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic [3:0]  wbs_sel_i;
  logic [2:0]  wbs_cti_i;
  logic [1:0]  wbs_bte_i;
  logic        wbs_ack_o, wbs_err_o, burst_active_o;
  logic [15:0] rd_cnt_o;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          exp_rd_cnt = 0;

  // clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vga_fb_wb_slave #(
    .AW(AW), .BASE_ADR(BASE), .WAIT_STATES(WS), .BURST_WAIT(BW)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i),
    .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .rd_cnt_o(rd_cnt_o), .burst_active_o(burst_active_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // word index of beat i of a burst, straight from the burst-type rules
  function automatic int beat_idx(input int start, input int i, input logic [1:0] bte);
    int len;
    case (bte)
      2'b00: return (start + i) % DEPTH;
      2'b01: len = 4;
      2'b10: len = 8;
      default: len = 16;
    endcase
    return (start / len) * len + ((start % len) + i) % len;
  endfunction

  // monitor: every acknowledged read beat consumes one expected word
  initial begin
    forever begin
      @(negedge clk);
      if (wbs_ack_o === 1'b1 && wbs_we_i === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read_ack: data %h with empty expectation queue", wbs_dat_o);
        end else begin
          chk("rd_data", wbs_dat_o, exp_q.pop_front());
        end
      end
    end
  end

  task automatic bus_idle();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = 4'hF;
    wbs_cti_i = CTI_CLASSIC; wbs_bte_i = BTE_LINEAR;
  endtask

  // driver: classic (n==1) or burst access; early keeps cti=010 to the end
  task automatic wb_burst(input int start, input int n, input logic we, input logic [1:0] bte,
                          input logic [3:0] sel, input bit early, input bit ramp);
    logic [31:0] wd [$];
    logic [31:0] d;
    int idx, beat, waited, lat, max_gap;
    bit a, timed_out;
    for (int i = 0; i < n; i++) begin
      idx = beat_idx(start, i, bte);
      if (we) begin
        d = ramp ? 32'(idx) : $urandom();
        wd.push_back(d);
        for (int b = 0; b < 4; b++) if (sel[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
      end else begin
        exp_q.push_back(mem_m[idx]);
      end
    end
    if (!we) exp_rd_cnt += n;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_sel_i = sel; wbs_bte_i = bte;
    beat = 0; waited = 0; lat = -1; max_gap = 0; timed_out = 0;
    while (beat < n && !timed_out) begin
      wbs_adr_i = BASE | (32'(beat_idx(start, beat, bte)) << 2);
      wbs_dat_i = we ? wd[beat] : 32'h0;
      if (n == 1) wbs_cti_i = CTI_CLASSIC;
      else if (beat == n - 1 && !early) wbs_cti_i = CTI_EOB;
      else wbs_cti_i = CTI_INCR;
      @(negedge clk);
      a = wbs_ack_o;
      chk("burst_active_in_xfer", {31'b0, burst_active_o}, {31'b0, (beat > 0)});
      if (a) begin
        if (beat == 0) lat = waited;
        else if (waited > max_gap) max_gap = waited;
      end
      @(posedge clk); #1;
      if (a) begin
        beat++;
        waited = 0;
      end else begin
        waited++;
        if (waited > 64) timed_out = 1;
      end
    end
    chk("xfer_timeout", {31'b0, timed_out}, 32'd0);
    chk("first_ack_latency", lat, WS + 1);
    if (n > 1) chk("burst_beat_gap", max_gap, BW);
    bus_idle();
    @(negedge clk);
    chk("ack_low_after_stb_drop", {31'b0, wbs_ack_o}, 32'd0);
    chk("burst_active_after_xfer", {31'b0, burst_active_o}, {31'b0, (early && n > 1)});
    @(posedge clk); #1;
  endtask

  // driver: access expected to be rejected with a one-cycle err
  task automatic wb_err(input logic [31:0] adr, input logic we);
    int waited;
    bit seen_err, seen_ack;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_adr_i = adr;
    wbs_dat_i = $urandom(); wbs_sel_i = 4'hF; wbs_cti_i = CTI_CLASSIC;
    seen_err = 0; seen_ack = 0; waited = 0;
    while (!seen_err && waited <= 64) begin
      @(negedge clk);
      if (wbs_err_o) seen_err = 1;
      if (wbs_ack_o) seen_ack = 1;
      @(posedge clk); #1;
      if (!seen_err) waited++;
    end
    chk("err_seen", {31'b0, seen_err}, 32'd1);
    chk("err_no_ack", {31'b0, seen_ack}, 32'd0);
    @(negedge clk);
    chk("err_one_cycle", {31'b0, wbs_err_o}, 32'd0);
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    int n, start;
    logic [1:0] bte;
    logic [3:0] sel;
    logic we;
    bit early;

    // reset state
    bus_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ack", {31'b0, wbs_ack_o}, 32'd0);
    chk("reset_err", {31'b0, wbs_err_o}, 32'd0);
    chk("reset_dat", wbs_dat_o, 32'd0);
    chk("reset_rd_cnt", {16'b0, rd_cnt_o}, 32'd0);
    chk("reset_burst_active", {31'b0, burst_active_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // preload mem[i] = i through the write port with one long linear burst
    wb_burst(0, DEPTH, 1'b1, BTE_LINEAR, 4'hF, 1'b0, 1'b1);

    // classic full write, partial write, read back
    wb_burst(4, 1, 1'b1, BTE_LINEAR, 4'hF, 1'b0, 1'b0);
    mem_m[4] = 32'hFFFF_FFFF;
    wbs_dat_i = 32'hFFFF_FFFF;
    // full-lane write with known data so the partial write result is fixed
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
    wbs_adr_i = 32'h10; wbs_cti_i = CTI_CLASSIC;
    repeat (2) @(posedge clk); #1;
    @(negedge clk);
    chk("fill_write_ack", {31'b0, wbs_ack_o}, 32'd1);
    @(posedge clk); #1;
    bus_idle();
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'b0011;
    wbs_adr_i = 32'h10; wbs_dat_i = 32'hA5A5_1234; wbs_cti_i = CTI_CLASSIC;
    repeat (2) @(posedge clk); #1;
    @(negedge clk);
    chk("partial_write_ack", {31'b0, wbs_ack_o}, 32'd1);
    @(posedge clk); #1;
    bus_idle();
    mem_m[4] = 32'hFFFF_1234;
    @(posedge clk); #1;
    wb_burst(4, 1, 1'b0, BTE_LINEAR, 4'hF, 1'b0, 1'b0);
    chk("rd_cnt_classic", {16'b0, rd_cnt_o}, exp_rd_cnt);

    // linear 8-beat read, wrap4 from 6, linear across the window end
    wb_burst(0, 8, 1'b0, BTE_LINEAR, 4'hF, 1'b0, 1'b0);
    chk("rd_cnt_linear8", {16'b0, rd_cnt_o}, exp_rd_cnt);
    wb_burst(6, 4, 1'b0, BTE_WRAP4, 4'hF, 1'b0, 1'b0);
    wb_burst(DEPTH - 1, 2, 1'b0, BTE_LINEAR, 4'hF, 1'b0, 1'b0);

    // out-of-window write and misaligned read, then prove word 0 untouched
    wb_err(32'h0000_4000, 1'b1);
    wb_err(32'h0000_0011, 1'b0);
    wb_burst(0, 1, 1'b0, BTE_LINEAR, 4'hF, 1'b0, 1'b0);

    // early termination after 3 beats, then a normal classic read
    wb_burst(20, 3, 1'b0, BTE_LINEAR, 4'hF, 1'b1, 1'b0);
    wb_burst(9, 1, 1'b0, BTE_LINEAR, 4'hF, 1'b0, 1'b0);
    chk("rd_cnt_after_early", {16'b0, rd_cnt_o}, exp_rd_cnt);

    // reset while the slave is waiting: the access must never be acked
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h10;
    wbs_cti_i = CTI_CLASSIC;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_wait_no_ack", {31'b0, wbs_ack_o}, 32'd0);
    chk("rst_in_wait_rd_cnt", {16'b0, rd_cnt_o}, 32'd0);
    chk("rst_in_wait_dat", wbs_dat_o, 32'd0);
    bus_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rd_cnt = 0;
    @(posedge clk); #1;
    wb_burst(4, 1, 1'b0, BTE_LINEAR, 4'hF, 1'b0, 1'b0);

    // randomized mix of classic, burst and error accesses
    for (int t = 0; t < 60; t++) begin
      bte = 2'($urandom_range(0, 3));
      n = $urandom_range(1, 10);
      start = ($urandom_range(0, 3) == 0) ? DEPTH - 1 - $urandom_range(0, 3)
                                          : $urandom_range(0, DEPTH - 1);
      we = 1'($urandom_range(0, 1));
      sel = 4'($urandom_range(1, 15));
      early = (n > 1) && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0)
        wb_err(32'h0000_4000 | (32'($urandom_range(0, DEPTH - 1)) << 2), we);
      else
        wb_burst(start, n, we, bte, sel, early, 1'b0);
      chk("rd_cnt_random", {16'b0, rd_cnt_o}, exp_rd_cnt);
    end

    repeat (4) @(posedge clk);
    chk("exp_queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
